pipe_seq_ctrl: RTL and testbench

//  Sequencer for an N-stage valid/ready register pipeline. Owns per-stage valid bits and drives per-stage

---
 rtl/pipe_seq_ctrl_pkg.sv | 11 +
 rtl/pipe_skid_buf.sv | 54 +++++
 rtl/pipe_seq_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: legal stage-count range and a range helper.
package pipe_seq_ctrl_pkg;

    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 8;

    function automatic bit stages_legal(input int n);
        return (n >= PIPE_STAGES_MIN) && (n <= PIPE_STAGES_MAX);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry valid/ready skid: passes through when empty, parks a stalled entry and drains it first.
module pipe_skid_buf
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_full
);

    logic          skid_v_reg;
    logic          skid_v_next;
    logic [DW-1:0] skid_d_reg;

    // Upstream only sees the registered occupancy, so i_ready never reaches o_ready.
    assign o_ready = ~skid_v_reg;
    assign o_valid = skid_v_reg | i_valid;
    assign o_data  = skid_v_reg ? skid_d_reg : i_data;
    assign o_full  = skid_v_reg;

    always_comb begin
        skid_v_next = skid_v_reg;
        if (i_flush) begin
            skid_v_next = 1'b0;
        end else if (skid_v_reg) begin
            skid_v_next = ~i_ready;
        end else begin
            skid_v_next = i_valid & ~i_ready;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            skid_v_reg <= 1'b0;
        end else begin
            skid_v_reg <= skid_v_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (~skid_v_reg & i_valid & ~i_ready) begin
            skid_d_reg <= i_data;
        end
    end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Valid/ready sequencer for an N-stage register pipeline with bubble collapse and synchronous flush.
// Define NCPU_PIPE_SKID_EN to add a one-entry skid after the last stage (breaks the i_ready->o_ready path).
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 2
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             i_flush,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DW-1:0]                    i_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [DW-1:0]                    o_data,
    output logic                             o_busy,
    output logic [$clog2(STAGES+2)-1:0]      o_occupancy
);

    localparam int OCW  = $clog2(STAGES + 2);
    localparam int LAST = STAGES - 1;

    generate
        if (!stages_legal(STAGES)) begin : g_bad_stages
            $fatal(1, "pipe_seq_ctrl: STAGES out of legal range");
        end
    endgenerate

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [DW-1:0]     data_reg [STAGES];
    logic              last_ready;
    logic              skid_v;
    logic              in_fire;

    // A stage advances when it is valid and the slot ahead is empty or itself advancing.
    always_comb begin
        adv       = '0;
        adv[LAST] = valid_reg[LAST] & last_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = valid_reg[k] & (~valid_reg[k+1] | adv[k+1]);
        end
    end

    assign o_ready = ~i_flush & (~valid_reg[0] | adv[0]);
    assign in_fire = i_valid & o_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign load[gi] = in_fire;
                always_ff @(posedge CLK) begin
                    if (load[gi]) begin
                        data_reg[gi] <= i_data;
                    end
                end
            end else begin : g_body
                assign load[gi] = adv[gi-1];
                always_ff @(posedge CLK) begin
                    if (load[gi]) begin
                        data_reg[gi] <= data_reg[gi-1];
                    end
                end
            end
            assign valid_next[gi] = ~i_flush & (load[gi] | (valid_reg[gi] & ~adv[gi]));
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

`ifdef NCPU_PIPE_SKID_EN
    pipe_skid_buf #(
        .DW (DW)
    ) u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .i_flush (i_flush),
        .i_valid (valid_reg[LAST]),
        .o_ready (last_ready),
        .i_data  (data_reg[LAST]),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_full  (skid_v)
    );
`else
    assign last_ready = i_ready;
    assign o_valid    = valid_reg[LAST];
    assign o_data     = data_reg[LAST];
    assign skid_v     = 1'b0;
`endif

    always_comb begin
        o_occupancy = OCW'(skid_v);
        for (int k = 0; k < STAGES; k++) begin
            o_occupancy = o_occupancy + OCW'(valid_reg[k]);
        end
    end

    assign o_busy = (|valid_reg) | skid_v;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: directed flow-control scenarios followed by random traffic.
module tb_pipe_seq_ctrl;

    localparam int DW = 32;
`ifdef NCPU_PIPE_SKID_EN
    localparam int STAGES = 1;
    localparam bit SKID   = 1'b1;
`else
    localparam int STAGES = 2;
    localparam bit SKID   = 1'b0;
`endif
    localparam int OCW = $clog2(STAGES + 2);
    localparam int CAP = SKID ? STAGES + 1 : STAGES;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           i_flush = 1'b0;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b0;
    logic [DW-1:0]  i_data = '0;
    logic           o_ready;
    logic           o_valid;
    logic [DW-1:0]  o_data;
    logic           o_busy;
    logic [OCW-1:0] o_occupancy;

    always #5 CLK = ~CLK;

    pipe_seq_ctrl #(
        .DW     (DW),
        .STAGES (STAGES)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_occupancy (o_occupancy)
    );

    // Reference model: entries in flight, in order, each tagged with its acceptance cycle.
    // An entry becomes visible STAGES cycles after acceptance, but never before the cycle
    // following the departure of the entry ahead of it.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t sb[$];
    int   cyc      = 0;
    int   last_dep = -100;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: compares DUT outputs with the model every cycle, then retires/admits entries.
    int n_m;
    int vis_m;
    bit exp_rdy;
    bit exp_vld;
    always @(negedge CLK) begin
        if (!RST && !done) begin
            n_m     = sb.size();
            exp_rdy = !i_flush && ((n_m < CAP) || (!SKID && i_ready));
            exp_vld = 1'b0;
            if (n_m > 0) begin
                vis_m = sb[0].t + STAGES;
                if (last_dep + 1 > vis_m) vis_m = last_dep + 1;
                exp_vld = (cyc >= vis_m);
            end
            chk("o_ready", 64'(o_ready), 64'(exp_rdy));
            chk("o_valid", 64'(o_valid), 64'(exp_vld));
            chk("o_occupancy", 64'(o_occupancy), 64'(n_m));
            chk("o_busy", 64'(o_busy), 64'(n_m > 0));
            if (exp_vld) chk("o_data", 64'(o_data), 64'(sb[0].d));
            if (exp_vld && i_ready) begin
                void'(sb.pop_front());
                last_dep = cyc;
            end
            if (i_flush) begin
                sb.delete();
            end else if (i_valid && exp_rdy) begin
                sb.push_back('{d: i_data, t: cyc});
            end
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f, output bit acc);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        @(negedge CLK);
        acc = v && o_ready;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            acc;
        logic [DW-1:0] d;
        int            acc_cyc;
        int            lat;

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_o_busy", 64'(o_busy), 64'd0);
        chk("reset_o_occupancy", 64'(o_occupancy), 64'd0);
        chk("reset_o_ready", 64'(o_ready), 64'd1);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Back-to-back stream with the consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0, acc);
            chk("stream_accept", 64'(acc), 64'd1);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, acc);

        // Backpressure, then release.
        d = 32'h1;
        for (int c = 0; c < 14; c++) begin
            drive(d <= 32'h3, d, c >= 6, 1'b0, acc);
            if (acc) d++;
        end

        // Bubble collapse: A, idle, B with the consumer stalled.
        drive(1'b1, 32'hA, 1'b0, 1'b0, acc);
        drive(1'b0, '0, 1'b0, 1'b0, acc);
        drive(1'b1, 32'hB, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, acc);

        // Flush while full and stalled; the offered input must not be taken.
        for (int i = 0; i < CAP + 1; i++) drive(1'b1, DW'(32'h10 + i), 1'b0, 1'b0, acc);
        drive(1'b1, 32'hEE, 1'b0, 1'b1, acc);
        chk("flush_no_accept", 64'(acc), 64'd0);
        i_flush = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("post_flush_o_valid", 64'(o_valid), 64'd0);
        chk("post_flush_occupancy", 64'(o_occupancy), 64'd0);
        chk("post_flush_o_ready", 64'(o_ready), 64'd1);
        @(posedge CLK);
        #1;

        // Asynchronous reset between edges while entries are in flight.
        for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'h20 + i), 1'b0, 1'b0, acc);
        i_valid = 1'b0;
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_o_valid", 64'(o_valid), 64'd0);
        chk("async_rst_o_busy", 64'(o_busy), 64'd0);
        chk("async_rst_occupancy", 64'(o_occupancy), 64'd0);
        sb.delete();
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        drive(1'b1, 32'h55, 1'b1, 1'b0, acc);
        chk("rst_recover_accept", 64'(acc), 64'd1);
        acc_cyc = cyc - 1;
        lat = -1;
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (lat < 0 && o_valid && o_data == 32'h55) lat = cyc - acc_cyc;
            @(posedge CLK);
            #1;
        end
        chk("latency_0x55", 64'(lat), 64'(STAGES));

        // Random traffic; with the skid, ready toggles every cycle.
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom,
                  SKID ? cyc[0] : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 39) == 0, acc);
        end

        for (int i = 0; i < CAP + 4; i++) drive(1'b0, '0, 1'b1, 1'b0, acc);
        chk("drain_model_empty", 64'(sb.size()), 64'd0);
        chk("drain_occupancy", 64'(o_occupancy), 64'd0);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
